// File: rtl/decade_2421_decoder_monitor.sv
// ============================================================================
// decade_2421_decoder_monitor
// ----------------------------------------------------------------------------
// Receive-side companion of a 2421 (Aiken) decade counter. Decodes a 2421
// digit stream back to BCD, flags illegal codes, checks that successive legal
// digits advance by +1 mod 10, and reports lock status, a 9->0 wrap count and
// a saturating error count. All outputs are registered (one cycle latency).
//
// Configuration macro: DEC2421_SEQ_CHECK_EN
//   defined   : ACQUIRE/TRACK/LOCK sequence FSM, SEQ_ERR, LOCK_N qualification.
//   undefined : no FSM; SEQ_ERR tied 0; LOCKED set by any legal code and
//               cleared by an illegal one; ERR_CNT counts code errors only;
//               WRAP_CNT counts a legal 9 directly followed by a legal 0.
//
// Parameters
//   CNT_W   width of WRAP_CNT (wraps modulo 2^CNT_W)
//   ERR_W   width of ERR_CNT (saturates at all-ones)
//   LOCK_N  consecutive in-sequence digits needed to assert LOCKED (>=1)
//
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   synchronous reset, active low
//   IN_VALID   in   IN_CODE is sampled this cycle
//   IN_CODE    in   2421 digit [3:0]
//   BCD        out  decoded digit (holds on gaps and illegal codes)
//   BCD_VALID  out  1-cycle pulse: BCD updated from a legal code
//   CODE_ERR   out  1-cycle pulse: illegal code received
//   SEQ_ERR    out  1-cycle pulse: legal code that is not prev+1 mod 10
//   LOCKED     out  level: stream is in sequence
//   WRAP_CNT   out  count of in-sequence 9->0 transitions
//   ERR_CNT    out  saturating count of CODE_ERR + SEQ_ERR events
// ============================================================================
module decade_2421_decoder_monitor #(
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 8,
    parameter int LOCK_N = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    input  logic [3:0]       IN_CODE,
    output logic [3:0]       BCD,
    output logic             BCD_VALID,
    output logic             CODE_ERR,
    output logic             SEQ_ERR,
    output logic             LOCKED,
    output logic [CNT_W-1:0] WRAP_CNT,
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam logic [CNT_W-1:0] WRAP_ONE = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    // Returns {legal, digit}; illegal codes return legal=0, digit=0.
    function automatic logic [4:0] decode_2421(input logic [3:0] code);
        logic [4:0] res;
        case (code)
            4'b0000: res = {1'b1, 4'd0};
            4'b0001: res = {1'b1, 4'd1};
            4'b0010: res = {1'b1, 4'd2};
            4'b0011: res = {1'b1, 4'd3};
            4'b0100: res = {1'b1, 4'd4};
            4'b1011: res = {1'b1, 4'd5};
            4'b1100: res = {1'b1, 4'd6};
            4'b1101: res = {1'b1, 4'd7};
            4'b1110: res = {1'b1, 4'd8};
            4'b1111: res = {1'b1, 4'd9};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    // Successor digit modulo 10.
    function automatic logic [3:0] next_digit(input logic [3:0] d);
        logic [3:0] res;
        if (d == 4'd9) begin
            res = 4'd0;
        end else begin
            res = d + 4'd1;
        end
        return res;
    endfunction

    // Saturating increment of the error counter.
    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] c);
        logic [ERR_W-1:0] res;
        if (c == ERR_MAX) begin
            res = c;
        end else begin
            res = c + ERR_ONE;
        end
        return res;
    endfunction

    logic             dec_legal_s;
    logic [3:0]       dec_val_s;
    logic             wrap_edge_s;

    logic [3:0]       bcd_q,       bcd_d;
    logic             bcd_valid_q, bcd_valid_d;
    logic             code_err_q,  code_err_d;
    logic             seq_err_q,   seq_err_d;
    logic             locked_q,    locked_d;
    logic [CNT_W-1:0] wrap_q,      wrap_d;
    logic [ERR_W-1:0] err_q,       err_d;
    logic [3:0]       ref_q,       ref_d;

    assign {dec_legal_s, dec_val_s} = decode_2421(IN_CODE);
    // A 9 followed by 0 is always the in-sequence successor of 9.
    assign wrap_edge_s = (ref_q == 4'd9) && (dec_val_s == 4'd0);

`ifdef DEC2421_SEQ_CHECK_EN

    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_PRE = GOOD_W'(LOCK_N - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_N);

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_LOCK    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [GOOD_W-1:0] good_q,  good_d;
    logic              in_seq_s;

    assign in_seq_s = (dec_val_s == next_digit(ref_q));

    // Next-state logic: decode, sequence FSM and counters.
    always_comb begin
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        code_err_d  = 1'b0;
        seq_err_d   = 1'b0;
        wrap_d      = wrap_q;
        err_d       = err_q;
        ref_d       = ref_q;
        state_d     = state_q;
        good_d      = good_q;
        if (IN_VALID) begin
            if (!dec_legal_s) begin
                code_err_d = 1'b1;
                err_d      = err_inc(err_q);
                state_d    = ST_ACQUIRE;
                good_d     = {GOOD_W{1'b0}};
            end else begin
                bcd_d       = dec_val_s;
                bcd_valid_d = 1'b1;
                ref_d       = dec_val_s;
                case (state_q)
                    ST_ACQUIRE: begin
                        good_d = GOOD_ONE;
                        if (LOCK_N == 1) begin
                            state_d = ST_LOCK;
                        end else begin
                            state_d = ST_TRACK;
                        end
                    end
                    ST_TRACK, ST_LOCK: begin
                        if (in_seq_s) begin
                            if (wrap_edge_s) begin
                                wrap_d = wrap_q + WRAP_ONE;
                            end else begin
                                wrap_d = wrap_q;
                            end
                            // good saturates at LOCK_N once the stream has locked
                            if (good_q >= GOOD_PRE) begin
                                good_d  = GOOD_MAX;
                                state_d = ST_LOCK;
                            end else begin
                                good_d  = good_q + GOOD_ONE;
                                state_d = ST_TRACK;
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            err_d     = err_inc(err_q);
                            good_d    = GOOD_ONE;
                            state_d   = ST_TRACK;
                        end
                    end
                    default: begin
                        state_d = ST_ACQUIRE;
                        good_d  = {GOOD_W{1'b0}};
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == ST_LOCK);
    end

    // FSM state and in-sequence run length.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_ACQUIRE;
            good_q  <= {GOOD_W{1'b0}};
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

`else

    // Tracks whether ref_q holds the directly preceding legal digit; an
    // illegal code breaks the 9->0 pairing just as it clears LOCKED.
    logic have_ref_q, have_ref_d;

    // Next-state logic without sequence checking.
    always_comb begin
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        code_err_d  = 1'b0;
        seq_err_d   = 1'b0;
        wrap_d      = wrap_q;
        err_d       = err_q;
        ref_d       = ref_q;
        locked_d    = locked_q;
        have_ref_d  = have_ref_q;
        if (IN_VALID) begin
            if (!dec_legal_s) begin
                code_err_d = 1'b1;
                err_d      = err_inc(err_q);
                locked_d   = 1'b0;
                have_ref_d = 1'b0;
            end else begin
                bcd_d       = dec_val_s;
                bcd_valid_d = 1'b1;
                ref_d       = dec_val_s;
                locked_d    = 1'b1;
                have_ref_d  = 1'b1;
                if (have_ref_q && wrap_edge_s) begin
                    wrap_d = wrap_q + WRAP_ONE;
                end else begin
                    wrap_d = wrap_q;
                end
            end
        end else begin
            have_ref_d = have_ref_q;
        end
    end

    // Validity of the reference digit.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            have_ref_q <= 1'b0;
        end else begin
            have_ref_q <= have_ref_d;
        end
    end

`endif

    // Output and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bcd_q       <= 4'd0;
            bcd_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
            wrap_q      <= {CNT_W{1'b0}};
            err_q       <= {ERR_W{1'b0}};
            ref_q       <= 4'd0;
        end else begin
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            code_err_q  <= code_err_d;
            seq_err_q   <= seq_err_d;
            locked_q    <= locked_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            ref_q       <= ref_d;
        end
    end

    assign BCD       = bcd_q;
    assign BCD_VALID = bcd_valid_q;
    assign CODE_ERR  = code_err_q;
    assign SEQ_ERR   = seq_err_q;
    assign LOCKED    = locked_q;
    assign WRAP_CNT  = wrap_q;
    assign ERR_CNT   = err_q;

endmodule
